// File: rtl/attn_out_collector.sv
// rtl/attn_out_collector.sv - stages attention output beats in a small FIFO and writes them to SRAM,
// sharing the single SRAM port with host reads (reads win while the FIFO has room).
module attn_out_collector #(
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [1:0]   in_row,
  input  logic [4:0]   in_group,
  input  logic [127:0] in_data,
  input  logic         rd_req,
  input  logic [6:0]   rd_addr,
  output logic         rd_gnt,
  output logic         rd_valid,
  output logic [127:0] rd_data,
  output logic         mem_web,
  output logic [6:0]   mem_addr,
  output logic [127:0] mem_din,
  input  logic [127:0] mem_q,
  output logic         busy,
  output logic         done,
  output logic         dup_err,
  output logic         ovf_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [6:0]      f_addr_q [FIFO_DEPTH];
  logic [127:0]    f_data_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    bitmap_q;
  logic            dup_q, ovf_q;
  logic [READ_LAT-1:0] vld_q;

  logic full, empty, gnt, pop, push, drop, beat;
  logic [6:0] head_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign empty     = (cnt_q == '0);
  assign head_addr = f_addr_q[rd_ptr_q];
  assign beat      = (state_q == S_COLLECT) && in_valid && !start;

  // Gated by rst so the SRAM port is quiet and rd_gnt low while reset is held.
  assign gnt  = !rst && rd_req && !full;
  assign pop  = !rst && !start && !gnt && !empty;
  assign push = beat && (!full || pop);
  assign drop = beat && full && !pop;

  assign rd_gnt   = gnt;
  assign mem_web  = !pop;
  assign mem_addr = gnt ? rd_addr : (pop ? head_addr : '0);
  assign mem_din  = pop ? f_data_q[rd_ptr_q] : '0;
  assign rd_valid = vld_q[READ_LAT-1];
  assign rd_data  = rd_valid ? mem_q : '0;
  assign busy     = (state_q == S_COLLECT);
  assign done     = (state_q == S_DONE);
  assign dup_err  = dup_q;
  assign ovf_err  = ovf_q;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_COLLECT;
    end else if (state_q == S_COLLECT && (&bitmap_q) && empty) begin
      state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      bitmap_q <= '0;
      dup_q    <= 1'b0;
      ovf_q    <= 1'b0;
      vld_q    <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= (vld_q << 1) | READ_LAT'(gnt);
      if (start) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        bitmap_q <= '0;
        dup_q    <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop) begin
          rd_ptr_q            <= ptr_inc(rd_ptr_q);
          bitmap_q[head_addr] <= 1'b1;
          if (bitmap_q[head_addr]) dup_q <= 1'b1;
        end
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_addr_q[wr_ptr_q] <= {in_group, in_row};
      f_data_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_attn_out_collector.sv
// tb/tb_attn_out_collector.sv - scoreboard bench for attn_out_collector with a 2-cycle SRAM model.
module tb_attn_out_collector;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, in_valid, rd_req;
  logic [1:0]   in_row;
  logic [4:0]   in_group;
  logic [127:0] in_data, rd_data, mem_din, mem_q;
  logic [6:0]   rd_addr, mem_addr;
  logic         rd_gnt, rd_valid, mem_web, busy, done, dup_err, ovf_err;

  attn_out_collector #(.READ_LAT(2), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_row(in_row),
    .in_group(in_group), .in_data(in_data), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .mem_web(mem_web),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q), .busy(busy), .done(done),
    .dup_err(dup_err), .ovf_err(ovf_err)
  );

  logic [127:0] mem [128];
  logic [127:0] rd_s1;
  always @(posedge clk) begin
    if (!mem_web) mem[mem_addr] <= mem_din;
    rd_s1 <= mem[mem_addr];
    mem_q <= rd_s1;
  end

  int total = 0, bad = 0, cyc = 0, gnt_total = 0;
  logic [134:0] wq[$];
  logic [127:0] rq[$];
  int           gq[$];
  logic [127:0] rd_exp_data;
  localparam logic [127:0] DEAD = {4{32'hDEAD_BEEF}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] d1(input logic [6:0] a);
    return {16{1'b0, a}};
  endfunction

  function automatic logic [127:0] d2(input logic [6:0] a);
    return ~d1(a);
  endfunction

  function automatic logic [6:0] perm(input int i);
    return 7'((i * 37 + 11) % 128);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd_valid: got data %h expected no read", rd_data);
        end else begin
          chk("rd_data", rd_data, rq.pop_front());
          chk("rd_latency", 135'(cyc - gq.pop_front()), 135'(2));
        end
      end
      if (rd_gnt) begin
        rq.push_back(rd_exp_data);
        gq.push_back(cyc);
        gnt_total++;
      end
      if (!mem_web) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_din);
        end else begin
          chk("sram_write", {mem_addr, mem_din}, wq.pop_front());
        end
      end
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic step(input int n);
    repeat (n) sync();
  endtask

  task automatic send(input logic [6:0] a, input logic [127:0] d, input bit expect_wr);
    in_valid = 1'b1; in_group = a[6:2]; in_row = a[1:0]; in_data = d;
    if (expect_wr) wq.push_back({a, d});
    sync();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  task automatic rd_one(input logic [6:0] a, input logic [127:0] exp);
    rd_req = 1'b1; rd_addr = a; rd_exp_data = exp;
    sync();
    rd_req = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int g0;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_row = '0; in_group = '0; in_data = '0;
    rd_req = 1'b0; rd_addr = '0; rd_exp_data = '0;
    #12;
    chk("reset_ctl", {rd_gnt, rd_valid, mem_web, busy, done, dup_err, ovf_err}, 7'b0010000);
    chk("reset_addr", mem_addr, 7'd0);
    chk("reset_rd_data", rd_data, 128'd0);
    sync(); rst = 1'b0; sync();

    // In-order stream, one beat per cycle.
    pulse_start();
    @(negedge clk); chk("busy_collect", {busy, done}, 2'b10);
    sync();
    for (int a = 0; a < 128; a++) send(7'(a), d1(7'(a)), 1'b1);
    @(negedge clk); chk("done_plus0", done, 1'b0);
    @(negedge clk); chk("done_plus1", done, 1'b0);
    @(negedge clk); chk("done_plus2", done, 1'b1);
    chk("flags_inorder", {busy, dup_err, ovf_err}, 3'b000);
    chk("writes_inorder", wq.size(), 0);
    sync();

    // in_valid in DONE is ignored.
    send(7'd9, DEAD, 1'b0);
    step(2);
    @(negedge clk); chk("done_ignore", {done, dup_err, ovf_err}, 3'b100);
    sync();
    rd_one(7'd0, d1(7'd0)); rd_one(7'd127, d1(7'd127)); rd_one(7'd64, d1(7'd64));
    step(4);
    chk("read_drain1", rq.size(), 0);

    // Permuted order; read requests held during a continuous stream, then gaps.
    pulse_start();
    g0 = gnt_total;
    rd_addr = perm(127); rd_exp_data = d1(perm(127)); rd_req = 1'b1;
    for (int i = 0; i < 64; i++) send(perm(i), d2(perm(i)), 1'b1);
    rd_req = 1'b0;
    @(negedge clk);
    chk("stream_grants", gnt_total - g0, 2);
    chk("stream_ovf", ovf_err, 1'b0);
    sync();
    for (int i = 64; i < 127; i++) begin
      send(perm(i), d2(perm(i)), 1'b1);
      if (i % 3 == 0) step(2);
    end
    step(3);
    @(negedge clk); chk("done_early_perm", done, 1'b0);
    sync();
    send(perm(127), d2(perm(127)), 1'b1);
    wait_done(10);
    chk("writes_perm", wq.size(), 0);
    chk("flags_perm", {dup_err, ovf_err}, 2'b00);
    sync();
    for (int a = 0; a < 128; a++) begin
      rd_req = 1'b1; rd_addr = 7'(a); rd_exp_data = d2(7'(a));
      sync();
    end
    rd_req = 1'b0;
    step(4);
    chk("read_drain2", rq.size(), 0);

    // Duplicate address.
    pulse_start();
    send(7'd5, d1(7'd5), 1'b1);
    send(7'd5, DEAD, 1'b1);
    for (int a = 0; a < 127; a++) if (a != 5) send(7'(a), d1(7'(a)), 1'b1);
    step(3);
    @(negedge clk); chk("done_early_dup", done, 1'b0); chk("dup_set", dup_err, 1'b1);
    sync();
    send(7'd127, d1(7'd127), 1'b1);
    wait_done(10);
    chk("flags_dup", {dup_err, ovf_err}, 2'b10);
    sync();
    rd_one(7'd5, DEAD); rd_one(7'd6, d1(7'd6));
    step(4);

    // Reset mid-collection.
    pulse_start();
    for (int a = 0; a < 40; a++) send(7'(a), d2(7'(a)), 1'b1);
    #2; rst = 1'b1; rd_req = 1'b1; rd_addr = 7'd7;
    #1;
    chk("rst_ctl", {rd_gnt, rd_valid, mem_web, busy, done, dup_err, ovf_err}, 7'b0010000);
    chk("rst_addr", mem_addr, 7'd0);
    chk("rst_din", mem_din, 128'd0);
    chk("rst_rd_data", rd_data, 128'd0);
    wq.delete(); rq.delete(); gq.delete();
    rd_req = 1'b0;
    step(2); rst = 1'b0; sync();

    // in_valid in IDLE is ignored.
    send(7'd20, DEAD, 1'b0);
    step(2);
    @(negedge clk); chk("idle_ignore", {busy, done, dup_err, ovf_err}, 4'b0000);
    sync();
    pulse_start();
    for (int a = 0; a < 128; a++) send(7'(a), d2(7'(a)), 1'b1);
    wait_done(10);
    chk("flags_after_rst", {dup_err, ovf_err}, 2'b00);
    sync();
    rd_one(7'd100, d2(7'd100)); rd_one(7'd20, d2(7'd20));
    step(4);
    chk("read_drain3", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
